key_schedule_seq: RTL and testbench
===================================

Name: key_schedule_seq

Overview:
Iterative AES-128 round-key generator.
- Loads a 128-bit key and emits the 11 round keys, one per accepted beat, to the round datapath.
- Encrypt mode: the input is the cipher key and keys come out in order 0..10.
- Decrypt mode: the input is the round-10 key and keys come out in order 10..0, using the inverse key schedule.
- Contains the g-function (RotWord, SubWord via the KeySubByte S-box instance, Rcon XOR) and its round/Rcon sequencing.

Parameters:
- NR, 10, number of rounds; fixed at 10 for AES-128. Other values are unsupported and the assertion fails at elaboration.

Ports:
- i_Clk  input  1  clock, rising edge
- i_Rst_n  input  1  asynchronous active-low reset
- i_Start  input  1  start pulse; sampled only in IDLE
- i_fDec  input  1  mode, sampled with i_Start: 0 = forward (encrypt), 1 = inverse (decrypt)
- i_Key  input  128  cipher key (fDec=0) or round-10 key (fDec=1); sampled with i_Start
- i_Ready  input  1  consumer accepts o_RoundKey when o_Valid && i_Ready
- o_RoundKey  output  128  current round key; word0 = [127:96]
- o_Round  output  4  round index of o_RoundKey (0..10)
- o_Valid  output  1  o_RoundKey/o_Round valid
- o_Last  output  1  current key is the final one (round 10 fwd, round 0 inv); qualified by o_Valid
- o_Busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async, i_Rst_n=0): state IDLE; all outputs 0 (o_RoundKey=0, o_Round=0, o_Valid=0, o_Last=0, o_Busy=0); internal key and mode registers cleared.
- FSM states: IDLE, EMIT.
- IDLE -> EMIT when i_Start=1:
  - Key register <= i_Key; mode <= i_fDec.
  - o_Round <= 0 if fwd, 10 if inv.
  - o_Valid=1 on the next cycle (latency 1 from start to first key).
- EMIT:
  - o_Valid=1 continuously.
  - Outputs hold stable while i_Ready=0 (no advance, no drop).
  - On a transfer (o_Valid && i_Ready) with o_Last=0: register <= next key, o_Round +1 (fwd) or -1 (inv); one key per cycle at full throughput.
  - On a transfer with o_Last=1: -> IDLE; o_Valid=0 next cycle; o_RoundKey keeps its last value.
- i_Start is ignored while o_Busy=1. i_fDec and i_Key are don't-care outside the start cycle.
- g(x, r): rot = {x[23:0], x[31:24]}; sub = S-box on each byte of rot; result = sub ^ {Rcon[r], 24'h0}.
- Rcon[r] for r=1..10: 01 02 04 08 10 20 40 80 1b 36.
- Forward step, round r-1 -> r (key words w0..w3):
  - t = g(w3, r)
  - w0' = w0^t; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'
- Inverse step, round r -> r-1:
  - w3' = w3^w2; w2' = w2^w1; w1' = w1^w0
  - w0' = w0 ^ g(w3', r)
- Next-key logic is combinational from the key register: one S-box instance, single-cycle path. No pipelining of the g-function.
- o_Last = o_Valid && (fwd ? o_Round==10 : o_Round==0).
- Simultaneous i_Start with the final transfer: i_Start is ignored because the state is still EMIT. A new run needs i_Start in IDLE, so the minimum gap between runs is one idle cycle.
- Reset asserted mid-run: immediate abort to the reset state; no partial keys are emitted after deassertion.

Test Plan:
1. Forward, FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, i_Ready=1: 11 beats on consecutive cycles; round 0 = input; round 1 = a0fafe1788542cb123a339392a6c7605; round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6 with o_Last=1; then o_Valid=0 and o_Busy=0.
2. Inverse, i_fDec=1, key d014f9a8c9ee2589e13f0cc8b6630ca6: o_Round runs 10..0; round 1 = a0fafe17...7605; round 0 = 2b7e1516...4f3c with o_Last=1.
3. Backpressure: toggle i_Ready pseudo-randomly during test 1. o_RoundKey/o_Round hold while i_Ready=0, and the key sequence is identical to test 1.
4. Start while busy: pulse i_Start with a different key at round 4. Sequence is unaffected; after the last beat, i_Start in IDLE begins the new key at round 0.
5. Async reset at round 6: pull i_Rst_n low mid-cycle. Outputs go to 0 immediately without a clock edge; after release, no o_Valid until a new i_Start.
6. All-zero key, forward: round 1 = 62636363626363636263636362636363; round 10 = b4ef5bcb3e92e21123e951cf6f8f188e.

Source files
------------

// File: rtl/key_schedule_seq.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : key_sub_byte / key_schedule_seq                             |
// | Desc     : Iterative AES-128 round-key generator. Emits round keys     |
// |            0..10 (encrypt) or 10..0 (decrypt), one per accepted beat,  |
// |            with a single shared g-function (RotWord/SubWord/Rcon).     |
// | Revision : 1.0 - initial release                                      |
// +------------------------------------------------------------------------+

// AES forward S-box, one byte in, one byte out, purely combinational.
module key_sub_byte (
    input  logic [7:0] i_Byte,
    output logic [7:0] o_Byte
);

    // Entry for input byte b sits at bits [(255-b)*8 +: 8], row 0 at the top.
    localparam logic [2047:0] c_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // (255 - b) * 8 is simply the inverted byte shifted up by three.
    assign o_Byte = c_SBOX[{~i_Byte, 3'b000} +: 8];

endmodule

module key_schedule_seq #(
    parameter int NR = 10
) (
    input  logic         i_Clk,
    input  logic         i_Rst_n,
    input  logic         i_Start,
    input  logic         i_fDec,
    input  logic [127:0] i_Key,
    input  logic         i_Ready,
    output logic [127:0] o_RoundKey,
    output logic [3:0]   o_Round,
    output logic         o_Valid,
    output logic         o_Last,
    output logic         o_Busy
);

    // Only the AES-128 schedule is implemented; any other round count is rejected.
    if (NR != 10) begin : g_nr_check
        $error("key_schedule_seq: NR must be 10 (AES-128)");
    end

    localparam logic [3:0] c_LAST_ROUND = 4'(NR);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_EMIT = 1'b1;

    logic [0:0]   state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [3:0]   round_q, round_d;
    logic         dec_q, dec_d;

    logic [31:0]  w_w0, w_w1, w_w2, w_w3;
    logic [31:0]  w_inv_w1, w_inv_w2, w_inv_w3;
    logic [31:0]  w_fwd_w0, w_fwd_w1, w_fwd_w2, w_fwd_w3;
    logic [31:0]  w_g_in, w_rot, w_sub, w_g;
    logic [3:0]   w_rcon_idx;
    logic [7:0]   w_rcon;
    logic [127:0] w_next_key;
    logic         w_final;
    logic         w_xfer;

    assign w_w0 = key_q[127:96];
    assign w_w1 = key_q[95:64];
    assign w_w2 = key_q[63:32];
    assign w_w3 = key_q[31:0];

    // Inverse step undoes the word chaining first; its g input is the recovered w3.
    assign w_inv_w3 = w_w3 ^ w_w2;
    assign w_inv_w2 = w_w2 ^ w_w1;
    assign w_inv_w1 = w_w1 ^ w_w0;

    // Shared g-function: both directions feed the same four S-box lookups.
    assign w_g_in     = dec_q ? w_inv_w3 : w_w3;
    assign w_rot      = {w_g_in[23:0], w_g_in[31:24]};
    // Forward r-1 -> r uses Rcon[r]; inverse r -> r-1 uses Rcon[r] as well.
    assign w_rcon_idx = dec_q ? round_q : (round_q + 4'd1);

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        key_sub_byte u_sbox (
            .i_Byte (w_rot[8*i +: 8]),
            .o_Byte (w_sub[8*i +: 8])
        );
    end

    // Round constant table for rounds 1..10.
    always_comb begin
        w_rcon = 8'h00;
        case (w_rcon_idx)
            4'd1:    w_rcon = 8'h01;
            4'd2:    w_rcon = 8'h02;
            4'd3:    w_rcon = 8'h04;
            4'd4:    w_rcon = 8'h08;
            4'd5:    w_rcon = 8'h10;
            4'd6:    w_rcon = 8'h20;
            4'd7:    w_rcon = 8'h40;
            4'd8:    w_rcon = 8'h80;
            4'd9:    w_rcon = 8'h1b;
            4'd10:   w_rcon = 8'h36;
            default: w_rcon = 8'h00;
        endcase
    end

    assign w_g = w_sub ^ {w_rcon, 24'h000000};

    assign w_fwd_w0 = w_w0 ^ w_g;
    assign w_fwd_w1 = w_w1 ^ w_fwd_w0;
    assign w_fwd_w2 = w_w2 ^ w_fwd_w1;
    assign w_fwd_w3 = w_w3 ^ w_fwd_w2;

    assign w_next_key = dec_q ? {w_w0 ^ w_g, w_inv_w1, w_inv_w2, w_inv_w3}
                              : {w_fwd_w0, w_fwd_w1, w_fwd_w2, w_fwd_w3};

    assign w_final = dec_q ? (round_q == 4'd0) : (round_q == c_LAST_ROUND);
    assign w_xfer  = o_Valid && i_Ready;

    // State register; reset aborts any run in progress.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q <= c_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: start only from IDLE, return after the final key is taken.
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE:  if (i_Start)            state_d = c_EMIT;
            c_EMIT:  if (w_xfer && w_final)  state_d = c_IDLE;
            default:                         state_d = c_IDLE;
        endcase
    end

    // Outputs decoded from state and the key/round registers.
    always_comb begin
        o_Valid    = (state_q == c_EMIT);
        o_Busy     = (state_q != c_IDLE);
        o_Last     = (state_q == c_EMIT) && w_final;
        o_RoundKey = key_q;
        o_Round    = round_q;
    end

    // Datapath next values: load on start, step on each non-final transfer, else hold.
    always_comb begin
        key_d   = key_q;
        round_d = round_q;
        dec_d   = dec_q;
        if ((state_q == c_IDLE) && i_Start) begin
            key_d   = i_Key;
            dec_d   = i_fDec;
            round_d = i_fDec ? c_LAST_ROUND : 4'd0;
        end else if ((state_q == c_EMIT) && w_xfer && !w_final) begin
            key_d   = w_next_key;
            round_d = dec_q ? (round_q - 4'd1) : (round_q + 4'd1);
        end
    end

    // Key, round and mode registers.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            key_q   <= '0;
            round_q <= '0;
            dec_q   <= 1'b0;
        end else begin
            key_q   <= key_d;
            round_q <= round_d;
            dec_q   <= dec_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_key_schedule_seq.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_key_schedule_seq                                         |
// | Desc     : Scoreboard bench for key_schedule_seq. Expected round keys  |
// |            come from a word-wise AES-128 expansion whose S-box is      |
// |            computed from GF(2^8) inversion plus the affine map.        |
// | Revision : 1.0 - initial release                                      |
// +------------------------------------------------------------------------+
module tb_key_schedule_seq;

    logic         clk = 1'b0;
    logic         i_Rst_n, i_Start, i_fDec, i_Ready;
    logic [127:0] i_Key;
    logic [127:0] o_RoundKey;
    logic [3:0]   o_Round;
    logic         o_Valid, o_Last, o_Busy;

    always #5 clk = ~clk;

    key_schedule_seq #(.NR(10)) dut (
        .i_Clk      (clk),
        .i_Rst_n    (i_Rst_n),
        .i_Start    (i_Start),
        .i_fDec     (i_fDec),
        .i_Key      (i_Key),
        .i_Ready    (i_Ready),
        .o_RoundKey (o_RoundKey),
        .o_Round    (o_Round),
        .o_Valid    (o_Valid),
        .o_Last     (o_Last),
        .o_Busy     (o_Busy)
    );

    typedef struct packed {
        logic [127:0] key;
        logic [3:0]   rnd;
        logic         last;
    } exp_t;

    exp_t         sb[$];
    int           total = 0;
    int           bad = 0;
    int           valid_cycles = 0;
    logic [127:0] mdl [0:10];
    logic [127:0] cap [0:15];
    bit           stall_q = 0;
    logic [127:0] hold_key;
    logic [3:0]   hold_rnd;

    localparam logic [127:0] K1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K1R1 = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] K1RA = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] KZR1 = 128'h62636363626363636263636362636363;
    localparam logic [127:0] KZRA = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xt(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_f(input logic [7:0] a);
        logic [7:0] inv = 8'h01;
        logic [7:0] s;
        for (int i = 0; i < 254; i++) inv = gmul(inv, a);
        s = inv;
        for (int i = 1; i <= 4; i++) begin
            inv = {inv[6:0], inv[7]};
            s = s ^ inv;
        end
        return s ^ 8'h63;
    endfunction

    task automatic expand(input logic [127:0] k);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_f(t[31:24]), sbox_f(t[23:16]), sbox_f(t[15:8]), sbox_f(t[7:0])};
                t = t ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) mdl[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic push_fwd();
        for (int r = 0; r <= 10; r++) sb.push_back('{mdl[r], 4'(r), (r == 10)});
    endtask

    task automatic push_inv();
        for (int r = 10; r >= 0; r--) sb.push_back('{mdl[r], 4'(r), (r == 0)});
    endtask

    // ---------------- output monitor ----------------
    always @(negedge clk) begin
        exp_t e;
        if (i_Rst_n && o_Valid) begin
            valid_cycles++;
            if (stall_q) begin
                chk("hold_key", o_RoundKey, hold_key);
                chk("hold_round", 128'(o_Round), 128'(hold_rnd));
            end
            if (i_Ready) begin
                stall_q = 0;
                total++;
                assert (sb.size() != 0) else begin
                    bad++;
                    $error("FAIL sb_unexpected observed=round %0d expected=no beat", o_Round);
                end
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("beat_key", o_RoundKey, e.key);
                    chk("beat_round", 128'(o_Round), 128'(e.rnd));
                    chk("beat_last", 128'(o_Last), 128'(e.last));
                    cap[o_Round] = o_RoundKey;
                end
            end else begin
                stall_q  = 1;
                hold_key = o_RoundKey;
                hold_rnd = o_Round;
            end
        end else begin
            stall_q = 0;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic start_run(input logic [127:0] k, input logic dec);
        for (int i = 0; i < 16; i++) cap[i] = '1;
        valid_cycles = 0;
        @(posedge clk); #1;
        i_Start = 1'b1; i_fDec = dec; i_Key = k;
        @(posedge clk); #1;
        i_Start = 1'b0; i_fDec = ~dec; i_Key = ~k;
        chk("first_valid", 128'(o_Valid), 128'(1));
        chk("first_round", 128'(o_Round), dec ? 128'(10) : 128'(0));
    endtask

    // Runs until IDLE (bounded); optionally random ready, a busy start pulse, or a reset.
    task automatic drain(input int max_cyc, input bit rnd, input int pulse_at, input int rst_at);
        bit done = 0;
        bit pulsed = 0;
        for (int c = 0; c < max_cyc; c++) begin
            i_Start = 1'b0;
            if (rst_at >= 0 && o_Valid && int'(o_Round) == rst_at) begin
                #1 i_Rst_n = 1'b0;
                sb.delete();
                #1;
                chk("arst_key", o_RoundKey, 128'h0);
                chk("arst_round", 128'(o_Round), 128'h0);
                chk("arst_valid", 128'(o_Valid), 128'h0);
                chk("arst_last", 128'(o_Last), 128'h0);
                chk("arst_busy", 128'(o_Busy), 128'h0);
                return;
            end
            if (!o_Busy) begin
                done = 1;
                break;
            end
            if (pulse_at >= 0 && !pulsed && int'(o_Round) == pulse_at) begin
                i_Start = 1'b1; i_fDec = 1'b0; i_Key = 128'h0;
                pulsed  = 1;
            end
            i_Ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk); #1;
        end
        i_Ready = 1'b1;
        i_Start = 1'b0;
        chk("drain_timeout", 128'(done), 128'(1));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        i_Rst_n = 1'b0; i_Start = 1'b0; i_fDec = 1'b0; i_Key = '0; i_Ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_key", o_RoundKey, 128'h0);
        chk("rst_round", 128'(o_Round), 128'h0);
        chk("rst_valid", 128'(o_Valid), 128'h0);
        chk("rst_last", 128'(o_Last), 128'h0);
        chk("rst_busy", 128'(o_Busy), 128'h0);
        i_Rst_n = 1'b1;

        // Forward, full throughput
        expand(K1);
        push_fwd();
        start_run(K1, 1'b0);
        drain(40, 0, -1, -1);
        chk("fwd_beats", 128'(valid_cycles), 128'(11));
        chk("fwd_r1", cap[1], K1R1);
        chk("fwd_r10", cap[10], K1RA);
        chk("fwd_end_valid", 128'(o_Valid), 128'h0);
        chk("fwd_end_busy", 128'(o_Busy), 128'h0);
        chk("fwd_end_keep", o_RoundKey, K1RA);
        chk("fwd_sb_empty", 128'(sb.size()), 128'h0);

        // Inverse from the round-10 key
        push_inv();
        start_run(K1RA, 1'b1);
        drain(40, 0, -1, -1);
        chk("inv_beats", 128'(valid_cycles), 128'(11));
        chk("inv_r1", cap[1], K1R1);
        chk("inv_r0", cap[0], K1);
        chk("inv_end_keep", o_RoundKey, K1);
        chk("inv_sb_empty", 128'(sb.size()), 128'h0);

        // Forward with random backpressure
        push_fwd();
        start_run(K1, 1'b0);
        drain(400, 1, -1, -1);
        chk("bp_r10", cap[10], K1RA);
        chk("bp_sb_empty", 128'(sb.size()), 128'h0);

        // Start pulse while busy is ignored; a start in IDLE then takes the new key
        push_fwd();
        start_run(K1, 1'b0);
        drain(40, 0, 4, -1);
        chk("busy_start_r10", cap[10], K1RA);
        chk("busy_start_sb_empty", 128'(sb.size()), 128'h0);
        expand(128'h0);
        push_fwd();
        start_run(128'h0, 1'b0);
        drain(40, 0, -1, -1);
        chk("zero_r1", cap[1], KZR1);
        chk("zero_r10", cap[10], KZRA);
        chk("zero_sb_empty", 128'(sb.size()), 128'h0);

        // Asynchronous reset mid-run
        expand(K1);
        push_fwd();
        start_run(K1, 1'b0);
        drain(40, 0, -1, 6);
        repeat (2) @(posedge clk);
        #1 i_Rst_n = 1'b1;
        valid_cycles = 0;
        repeat (6) @(posedge clk);
        #1;
        chk("post_rst_no_valid", 128'(valid_cycles), 128'h0);
        chk("post_rst_busy", 128'(o_Busy), 128'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
